// File: rtl/hilo_div_ctrl.sv
// Purpose : sequencer for a multi-cycle radix-2 restoring divider (DIV/DIVU) feeding the hi/lo write path.
// Latency : start in cycle 0 -> DONE in cycle DATA_WIDTH+2; a zero divisor reaches DONE in cycle 1.
// Backpr. : stall_req holds IF/ID/EX while busy; start is ignored outside IDLE; annul abandons the operation.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   start, signed_div             divide request and DIV(1)/DIVU(0) select, sampled in IDLE
//   dividend, divisor             operands, sampled with start
//   annul                         flush; next state IDLE, no write pulse, outputs keep their values
//   stall_req                     pipeline hold request (combinational)
//   ready, we_hi, we_lo           one-cycle result strobes in DONE
//   hi_out, lo_out, div_by_zero   remainder, quotient, zero-divisor flag (held until the next DONE)
module hilo_div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  annul,
    output logic                  stall_req,
    output logic                  ready,
    output logic                  we_hi,
    output logic                  we_lo,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  rem_q,   rem_d;   // partial remainder
    logic [W-1:0]  quo_q,   quo_d;   // dividend magnitude shifting out, quotient bits shifting in
    logic [W-1:0]  dvs_q,   dvs_d;   // divisor magnitude
    logic          sd_q,    sd_d;    // signed operation
    logic          sa_q,    sa_d;    // dividend negative (signed mode only)
    logic          sb_q,    sb_d;    // divisor negative (signed mode only)
    logic [W-1:0]  hi_q,    hi_d;
    logic [W-1:0]  lo_q,    lo_d;
    logic          dbz_q,   dbz_d;

    // One restoring step: the shifted remainder is W+1 bits wide so the
    // carried-out MSB takes part in the trial compare. When the trial
    // succeeds the difference is below the divisor, so W bits hold it.
    logic [W:0]   rem_sh;
    logic         trial_ge;
    logic [W-1:0] trial_diff;
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;

    always_comb begin
        rem_sh     = {rem_q, quo_q[W-1]};
        trial_ge   = (rem_sh >= {1'b0, dvs_q});
        trial_diff = rem_sh[W-1:0] - dvs_q;
        // Quotient sign is the XOR of operand signs; remainder follows the dividend.
        quo_fix    = (sd_q && (sa_q ^ sb_q)) ? (~quo_q + 1'b1) : quo_q;
        rem_fix    = (sd_q && sa_q) ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sd_d    = sd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sd_d = signed_div;
                    sa_d = signed_div & dividend[W-1];
                    sb_d = signed_div & divisor[W-1];
                    if (divisor == '0) begin
                        // Short-circuit: raw dividend to hi, all ones to lo.
                        hi_d    = dividend;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // Magnitudes are unsigned, so the most negative value maps to itself.
                        quo_d   = (signed_div && dividend[W-1]) ? (~dividend + 1'b1) : dividend;
                        dvs_d   = (signed_div && divisor[W-1])  ? (~divisor + 1'b1)  : divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = trial_ge ? trial_diff : rem_sh[W-1:0];
                quo_d = {quo_q[W-2:0], trial_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = rem_fix;
                lo_d    = quo_fix;
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything but reset: drop the operation and keep
        // the previously committed result visible.
        if (annul) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sd_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sd_q    <= sd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // A flush releases the pipeline in the same cycle and suppresses any commit.
    assign stall_req   = ~annul & (((state_q == S_IDLE) & start) |
                                   (state_q == S_CALC) | (state_q == S_FIX));
    assign ready       = (state_q == S_DONE);
    assign we_hi       = (state_q == S_DONE) & ~annul;
    assign we_lo       = (state_q == S_DONE) & ~annul;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Purpose : directed self-checking bench for hilo_div_ctrl.
// Latency : checks the 34-cycle divide and 1-cycle zero-divisor timing cycle by cycle.
// Backpr. : drives annul, reset and stray start pulses against the stall/ready protocol.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall_req;
    logic        ready;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    hilo_div_ctrl #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .dividend    (dividend),
        .divisor     (divisor),
        .annul       (annul),
        .stall_req   (stall_req),
        .ready       (ready),
        .we_hi       (we_hi),
        .we_lo       (we_lo),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide in the current cycle (cycle 0) and checks every cycle
    // up to and including DONE in cycle lat. Operands are scrambled after
    // cycle 0 so the result must come from the latched copies.
    task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dbz);
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                chk({tag, ".stall"}, {31'd0, stall_req}, 32'd1);
                chk({tag, ".ready"}, {31'd0, ready}, 32'd0);
                chk({tag, ".we"},    {30'd0, we_hi, we_lo}, 32'd0);
            end else begin
                chk({tag, ".done_stall"}, {31'd0, stall_req}, 32'd0);
                chk({tag, ".done_ready"}, {31'd0, ready}, 32'd1);
                chk({tag, ".done_we"},    {30'd0, we_hi, we_lo}, 32'd3);
                chk({tag, ".lo"},         lo_out, exp_lo);
                chk({tag, ".hi"},         hi_out, exp_hi);
                chk({tag, ".dbz"},        {31'd0, div_by_zero}, {31'd0, exp_dbz});
            end
            next_cycle();
            if (c == 0) begin
                start      = 1'b0;
                signed_div = ~sd;
                dividend   = ~a;
                divisor    = ~b;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        annul      = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.stall", {31'd0, stall_req}, 32'd0);
        chk("rst.ready", {31'd0, ready}, 32'd0);
        chk("rst.we",    {30'd0, we_hi, we_lo}, 32'd0);
        chk("rst.dbz",   {31'd0, div_by_zero}, 32'd0);
        chk("rst.lo",    lo_out, 32'd0);
        chk("rst.hi",    hi_out, 32'd0);
        next_cycle();

        // Directed divides, issued back to back (start in the cycle after DONE)
        do_div("divu_100_7",  1'b0, 32'd100,        32'd7,          34, 32'd14,         32'd2,          1'b0);
        do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        do_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  34, 32'hFFFF_FFFD,  32'd1,          1'b0);
        do_div("div_5_0",     1'b1, 32'd5,          32'd0,          1,  32'hFFFF_FFFF,  32'd5,          1'b1);
        do_div("div_9_3",     1'b1, 32'd9,          32'd3,          34, 32'd3,          32'd0,          1'b0);
        do_div("div_m100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,          34, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
        do_div("divu_big_10", 1'b0, 32'hFFFF_FFFF,  32'd10,         34, 32'h1999_9999,  32'd5,          1'b0);
        do_div("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  34, 32'h8000_0000,  32'd0,          1'b0);
        do_div("divu_ovf",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  34, 32'd0,          32'h8000_0000,  1'b0);

        // Idle after DONE
        @(negedge clk);
        chk("idle.stall", {31'd0, stall_req}, 32'd0);
        chk("idle.ready", {31'd0, ready}, 32'd0);
        next_cycle();

        // Annul in cycle 10 of 100/7, new divide 9/3 in cycle 11
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            chk("annul.pre_we", {30'd0, we_hi, we_lo}, 32'd0);
            next_cycle();
        end
        annul = 1'b1;
        start = 1'b1;                         // start with annul in CALC must not matter
        @(negedge clk);
        chk("annul.we", {30'd0, we_hi, we_lo}, 32'd0);
        next_cycle();
        annul = 1'b0;
        start = 1'b0;
        chk("annul.ready", {31'd0, ready}, 32'd0);
        chk("annul.lo",    lo_out, 32'd0);
        chk("annul.hi",    hi_out, 32'h8000_0000);
        do_div("annul_9_3", 1'b1, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

        // Annul together with start in IDLE: start ignored
        annul      = 1'b1;
        start      = 1'b1;
        dividend   = 32'd50;
        divisor    = 32'd5;
        signed_div = 1'b0;
        next_cycle();
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("annul_idle.stall", {31'd0, stall_req}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
        end
        @(negedge clk);
        chk("annul_idle.ready", {31'd0, ready}, 32'd0);
        chk("annul_idle.lo",    lo_out, 32'd3);
        next_cycle();

        // Reset in cycle 20 with start held high through CALC
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        next_cycle();
        dividend = 32'd40;
        divisor  = 32'd4;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            chk("rstmid.stall", {31'd0, stall_req}, 32'd1);
            chk("rstmid.ready", {31'd0, ready}, 32'd0);
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rstmid.after_stall", {31'd0, stall_req}, 32'd0);
        chk("rstmid.after_ready", {31'd0, ready}, 32'd0);
        chk("rstmid.after_lo",    lo_out, 32'd0);
        chk("rstmid.after_hi",    hi_out, 32'd0);
        chk("rstmid.after_dbz",   {31'd0, div_by_zero}, 32'd0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
